// File: rtl/lsu_ctrl.sv
// Load/store unit bus sequencer: one memory operation at a time, byte-lane steering and load extension.
// Optional request timeout is compiled in with `define LSU_TIMEOUT_EN (default build: wait forever for mem_ack).
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        MemWrite,
  input  logic [2:0]  DMOp,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | waiting for op_valid; alignment checked here
  // REQ   | bus request outstanding, waiting for mem_ack
  // DONE  | transfer complete; load_valid pulses for loads
  // ERR   | err_code pulses (misaligned or timeout)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [2:0] OP_WORD  = 3'b000;
  localparam logic [2:0] OP_LB    = 3'b001;
  localparam logic [2:0] OP_LH    = 3'b010;
  localparam logic [2:0] OP_SB    = 3'b011;
  localparam logic [2:0] OP_SH    = 3'b100;
  localparam logic [2:0] OP_LBOEZ = 3'b101;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [1:0]  err_q;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] to_cnt;
`endif

  always_comb begin
    misaligned = 1'b0;
    case (DMOp)
      OP_LH, OP_SH:            misaligned = addr[0];
      OP_LB, OP_SB, OP_LBOEZ:  misaligned = 1'b0;
      default:                 misaligned = |addr[1:0];
    endcase
  end

  // Loads always fetch the whole word; lane selection happens on return.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = write_data;
    if (MemWrite) begin
      case (DMOp)
        OP_SB: begin
          be_calc    = 4'b0001 << addr[1:0];
          wdata_calc = {4{write_data[7:0]}};
        end
        OP_SH: begin
          be_calc    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_calc = {2{write_data[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = write_data;
        end
      endcase
    end
  end

  always_comb begin
    sel_byte = mem_rdata[{off_q, 3'b000} +: 8];
    sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:    ext_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LH:    ext_data = {{16{sel_half[15]}}, sel_half};
      OP_LBOEZ: ext_data = ($countones(sel_byte) == 4) ? {{24{sel_byte[7]}}, sel_byte} : 32'h0;
      default:  ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= OP_WORD;
      we_q      <= 1'b0;
      off_q     <= 2'b00;
      err_q     <= 2'b00;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      load_data <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      to_cnt    <= 8'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (misaligned) begin
              state <= S_ERR;
              err_q <= 2'b01;
            end else begin
              state     <= S_REQ;
              op_q      <= DMOp;
              we_q      <= MemWrite;
              off_q     <= addr[1:0];
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
`ifdef LSU_TIMEOUT_EN
              to_cnt    <= 8'h0;
`endif
            end
          end
        end
        S_REQ: begin
          // An ack in the expiry cycle still completes the transfer.
          if (mem_ack) begin
            state <= S_DONE;
            if (!we_q) load_data <= ext_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (to_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state <= S_ERR;
            err_q <= 2'b10;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = (state == S_REQ);
  assign mem_we     = (state == S_REQ) && we_q;
  assign load_valid = (state == S_DONE) && !we_q;
  assign err_code   = (state == S_ERR) ? err_q : 2'b00;
  assign stall      = op_valid && (state != S_DONE) && (state != S_ERR);

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, number of REQ-state cycles without mem_ack before abort; valid range 2..255; used only with LSU_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op_valid  input  1  pipeline presents a memory operation.
REQ-005 MemWrite  input  1  1 = store, 0 = load.
REQ-006 DMOp  input  3  000 word, 001 Lb, 010 Lh, 011 Sb, 100 Sh, 101 Lboez.
REQ-007 addr  input  32  byte address.
REQ-008 write_data  input  32  store data, LSB-aligned.
REQ-009 stall  output  1  freeze the pipeline.
REQ-010 load_valid  output  1  one-cycle pulse; load_data is valid.
REQ-011 load_data  output  32  extended load result.
REQ-012 err_code  output  2  one-cycle pulse: 01 misaligned, 10 timeout, 00 none.
REQ-013 mem_req, mem_we  output  1 each  bus request and write strobe.
REQ-014 mem_addr  output  32  word address with bits [1:0] = 00.
REQ-015 mem_be  output  4  byte enables, bit k = byte lane k (bits 8k+7:8k).
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_ack  input  1, mem_rdata  input  32  bus completion and read word.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, DONE and ERR.
REQ-019 In IDLE with op_valid=1 and an aligned access, the block SHALL register addr, DMOp, MemWrite and write_data, and SHALL enter REQ.
REQ-020 The alignment rule SHALL be: Lh/Sh misaligned if addr[0]=1; word misaligned if addr[1:0]!=00; Lb, Sb and Lboez are never misaligned.
REQ-021 In IDLE with op_valid=1 and a misaligned access, the block SHALL enter ERR without issuing a bus request; ERR SHALL drive err_code=01 for one cycle and then return to IDLE.
REQ-022 mem_req SHALL equal 1 exactly while in REQ; mem_addr, mem_we, mem_be and mem_wdata SHALL be held stable while in REQ.
REQ-023 The mem_be rules SHALL be: loads 1111; word store 1111; Sb 1 shifted left by addr[1:0]; Sh 0011 if addr[1]=0, else 1100.
REQ-024 mem_wdata SHALL be: Sb {4{write_data[7:0]}}; Sh {2{write_data[15:0]}}; word store write_data.
REQ-025 In REQ with mem_ack=1 at a posedge, the block SHALL enter DONE and register mem_rdata; mem_ack outside REQ SHALL be ignored.
REQ-026 Minimum latency SHALL be: accept at cycle N, mem_req at N+1, ack at N+1, DONE at N+2.
REQ-027 In DONE, load_valid SHALL be 1 for loads and 0 for stores; the state SHALL return to IDLE on the next cycle.
REQ-028 load_data extraction SHALL use the registered byte offset: Lb sign-extends the selected byte; Lh sign-extends the selected half; word passes through; Lboez gives the sign-extended byte if the popcount of that byte is 4, else 0.
REQ-029 stall SHALL equal op_valid AND state is not DONE AND state is not ERR, so the pipeline advances after DONE or ERR.
REQ-030 load_data SHALL hold its last value outside DONE.

Reset
REQ-031 While reset=0, the block SHALL immediately force state IDLE, with mem_req, mem_we, load_valid, stall-internal state, err_code, mem_be, mem_addr, mem_wdata and load_data all 0.
REQ-032 A reset asserted mid-REQ SHALL abandon the transaction; a later mem_ack SHALL have no effect.

Configuration
REQ-033 With LSU_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry and increment each REQ cycle without ack; on reaching TIMEOUT_CYCLES it SHALL drop mem_req, enter ERR and drive err_code=10; mem_ack in the same cycle as expiry SHALL win.
REQ-034 Without LSU_TIMEOUT_EN, no counter SHALL exist, REQ SHALL wait indefinitely, and err_code SHALL never be 10.

Verification
REQ-035 Sb addr=0x0000_1003, write_data=0x0000_00A5, ack immediate: mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, mem_we=1; stall for 2 cycles.
REQ-036 Lh addr=0x2002, mem_rdata=0x8001_1234, ack after 3 cycles: load_valid=1 with load_data=0xFFFF8001.
REQ-037 Lboez addr=0x0001, rdata byte1=0x0F then 0x07: load_data=0x0000000F, then 0.
REQ-038 Word load addr=0x0006: no mem_req, err_code=01 for one cycle, stall released.
REQ-039 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack: mem_req high 4 cycles, then err_code=10; a separate run with reset low during REQ drops mem_req asynchronously and a later ack is ignored.
